// File: rtl/memory_map_pkg.sv
// Address map constants and region decode shared by the memory map and its benches.
// PULSE(sig, clk) drives sig high for one rising edge of clk (bench helper).
`ifndef PULSE
`define PULSE(sig, clk) begin sig = 1'b1; @(posedge clk); #1 sig = 1'b0; end
`endif

package memory_map_pkg;

    localparam logic [15:0] RAM_START  = 16'h2000;
    localparam logic [15:0] RAM_LEN    = 16'h0400;
    localparam logic [15:0] FRAM_START = 16'hC400;
    localparam logic [15:0] FRAM_LEN   = 16'h3C00;

    localparam int RAM_DEPTH  = int'(RAM_LEN);
    localparam int FRAM_DEPTH = int'(FRAM_LEN);

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_FRAM
    } region_t;

    // Region ends are computed in 17 bits so a region reaching 0xFFFF cannot wrap.
    function automatic region_t decode_region(input logic [15:0] addr);
        logic [16:0] a;
        a = {1'b0, addr};
        if (a >= {1'b0, RAM_START} && a < ({1'b0, RAM_START} + {1'b0, RAM_LEN}))
            return REGION_RAM;
        if (a >= {1'b0, FRAM_START} && a < ({1'b0, FRAM_START} + {1'b0, FRAM_LEN}))
            return REGION_FRAM;
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/memory_map_byte_mem.sv
// Little-endian byte array with combinational word/byte read and clocked word/byte write.
// CLEAR_ON_RST selects whether a synchronous reset zeroes the contents.
module byte_mem #(
    parameter int DEPTH        = 1024,
    parameter bit CLEAR_ON_RST = 1'b0,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    input  logic          we,
    input  logic          bw,
    output logic [15:0]   rdata
);

    logic [7:0]    memory [DEPTH];
    logic [AW-1:0] addr_lo;
    logic [AW-1:0] addr_hi;

    // Word accesses ignore addr[0]; both halves of the pair lie inside the array since DEPTH is even.
    assign addr_lo = {addr[AW-1:1], 1'b0};
    assign addr_hi = {addr[AW-1:1], 1'b1};

    assign rdata = bw ? {8'h00, memory[addr]} : {memory[addr_hi], memory[addr_lo]};

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RST) begin
                for (int i = 0; i < DEPTH; i++)
                    memory[i] <= 8'h00;
            end
        end else if (we) begin
            if (bw) begin
                memory[addr] <= wdata[7:0];
            end else begin
                memory[addr_lo] <= wdata[7:0];
                memory[addr_hi] <= wdata[15:8];
            end
        end
    end

endmodule

// File: rtl/memory_map.sv
// Unified RAM/FRAM memory map: address decode and read-data muxing only.
// Define MEMMAP_FRAM_WP_EN to write-protect the FRAM region.
module memory_map
    import memory_map_pkg::*;
(
    input  logic        MCLK,
    input  logic        rst,
    input  logic [15:0] MAB,
    input  logic [15:0] MDBwrite,
    output logic [15:0] MDBread,
    input  logic        MW,
    input  logic        BW
);

    localparam int RAM_AW  = $clog2(RAM_DEPTH);
    localparam int FRAM_AW = $clog2(FRAM_DEPTH);

    region_t            region;
    logic [RAM_AW-1:0]  ram_off;
    logic [FRAM_AW-1:0] fram_off;
    logic [15:0]        ram_rdata;
    logic [15:0]        fram_rdata;
    logic               ram_we;
    logic               fram_we;

    assign region   = decode_region(MAB);
    assign ram_off  = RAM_AW'(MAB - RAM_START);
    assign fram_off = FRAM_AW'(MAB - FRAM_START);

    // Reset takes priority over a coincident write in both regions.
    assign ram_we = MW && !rst && (region == REGION_RAM);
`ifdef MEMMAP_FRAM_WP_EN
    assign fram_we = 1'b0;
`else
    assign fram_we = MW && !rst && (region == REGION_FRAM);
`endif

    byte_mem #(
        .DEPTH        (RAM_DEPTH),
        .CLEAR_ON_RST (1'b1)
    ) RAM (
        .clk   (MCLK),
        .rst   (rst),
        .addr  (ram_off),
        .wdata (MDBwrite),
        .we    (ram_we),
        .bw    (BW),
        .rdata (ram_rdata)
    );

    byte_mem #(
        .DEPTH        (FRAM_DEPTH),
        .CLEAR_ON_RST (1'b0)
    ) FRAM (
        .clk   (MCLK),
        .rst   (rst),
        .addr  (fram_off),
        .wdata (MDBwrite),
        .we    (fram_we),
        .bw    (BW),
        .rdata (fram_rdata)
    );

    always_comb begin
        MDBread = 16'h0000;
        if (!rst) begin
            case (region)
                REGION_RAM:  MDBread = ram_rdata;
                REGION_FRAM: MDBread = fram_rdata;
                default:     MDBread = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_map.sv
// Self-checking bench for memory_map: vector table through a scoreboard queue plus reset sequences.
module tb_memory_map;

    logic        MCLK = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] MAB = 16'h0000;
    logic [15:0] MDBwrite = 16'h0000;
    logic [15:0] MDBread;
    logic        MW = 1'b0;
    logic        BW = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       name;
        logic [15:0] mab;
        logic        bw;
        logic        mw;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    logic [15:0] fram_c400_exp;

    memory_map dut (
        .MCLK     (MCLK),
        .rst      (rst),
        .MAB      (MAB),
        .MDBwrite (MDBwrite),
        .MDBread  (MDBread),
        .MW       (MW),
        .BW       (BW)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [15:0] mab, input logic bw,
                                input logic mw, input logic [15:0] wdata, input logic [15:0] exp);
        vec_t v;
        v.name = name; v.mab = mab; v.bw = bw; v.mw = mw; v.wdata = wdata; v.exp = exp;
        return v;
    endfunction

    // Drive at the falling edge, compare the combinational read, then let the rising edge commit any write.
    task automatic apply(input vec_t v);
        logic [15:0] e;
        @(negedge MCLK);
        MAB = v.mab; BW = v.bw; MW = v.mw; MDBwrite = v.wdata;
        exp_q.push_back(v.exp);
        #1;
        if (exp_q.size() == 0) begin
            check({v.name, "_queue_empty"}, 16'hFFFF, 16'h0000);
        end else begin
            e = exp_q.pop_front();
            check(v.name, MDBread, e);
        end
        @(posedge MCLK);
        #1 MW = 1'b0;
    endtask

    initial begin
        dut.FRAM.memory[0]     = 8'h31;
        dut.FRAM.memory[1]     = 8'h40;
        dut.FRAM.memory[2]     = 8'h57;
        dut.FRAM.memory[3]     = 8'h13;
        dut.FRAM.memory[15358] = 8'hA5;
        dut.FRAM.memory[15359] = 8'hA5;

`ifdef MEMMAP_FRAM_WP_EN
        fram_c400_exp = 16'h4031;
`else
        fram_c400_exp = 16'h5678;
`endif

        vecs.push_back(mk("unmapped_1ffe_rd",   16'h1FFE, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk("unmapped_1ffe_wr",   16'h1FFE, 0, 1, 16'h1234, 16'h0000));
        vecs.push_back(mk("ram_2000_rd0",       16'h2000, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk("ram_2000_wr",        16'h2000, 0, 1, 16'h5678, 16'h0000));
        vecs.push_back(mk("ram_2000_rd",        16'h2000, 0, 0, 16'h0000, 16'h5678));
        vecs.push_back(mk("ram_2001_word_algn", 16'h2001, 0, 0, 16'h0000, 16'h5678));
        vecs.push_back(mk("ram_2001_byte",      16'h2001, 1, 0, 16'h0000, 16'h0056));
        vecs.push_back(mk("ram_2000_byte",      16'h2000, 1, 0, 16'h0000, 16'h0078));
        vecs.push_back(mk("past_ram_2400_wr",   16'h2400, 0, 1, 16'h1111, 16'h0000));
        vecs.push_back(mk("past_ram_2400_rd",   16'h2400, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk("below_fram_c3fe_wr", 16'hC3FE, 0, 1, 16'h2222, 16'h0000));
        vecs.push_back(mk("below_fram_c3fe_rd", 16'hC3FE, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk("fram_c400_preload",  16'hC400, 0, 0, 16'h0000, 16'h4031));
        vecs.push_back(mk("fram_c400_wr",       16'hC400, 0, 1, 16'h5678, 16'h4031));
        vecs.push_back(mk("fram_c400_after_wr", 16'hC400, 0, 0, 16'h0000, fram_c400_exp));
        vecs.push_back(mk("fram_fffe_ivt",      16'hFFFE, 0, 0, 16'h0000, 16'hA5A5));
        vecs.push_back(mk("fram_ffff_byte",     16'hFFFF, 1, 0, 16'h0000, 16'h00A5));
        vecs.push_back(mk("ram_23fe_wr0",       16'h23FE, 0, 1, 16'h0000, 16'h0000));
        vecs.push_back(mk("ram_23fe_bwr",       16'h23FE, 1, 1, 16'h00A5, 16'h0000));
        vecs.push_back(mk("ram_23fe_byte_rd",   16'h23FE, 1, 0, 16'h0000, 16'h00A5));
        vecs.push_back(mk("ram_23fe_word_rd",   16'h23FE, 0, 0, 16'h0000, 16'h00A5));
        vecs.push_back(mk("ram_23ff_bwr",       16'h23FF, 1, 1, 16'hFFC3, 16'h0000));
        vecs.push_back(mk("ram_23fe_word_rd2",  16'h23FE, 0, 0, 16'h0000, 16'hC3A5));

        // Reset: read is forced to zero even on a preloaded FRAM word.
        MAB = 16'hC400;
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        check("reset_read_zero", MDBread, 16'h0000);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        check("ram_mem0_byte", {8'h00, dut.RAM.memory[0]}, 16'h0078);
        check("ram_mem1_byte", {8'h00, dut.RAM.memory[1]}, 16'h0056);

        // Reset coincident with writes to RAM and FRAM: both writes dropped, RAM cleared.
        @(negedge MCLK);
        rst = 1'b1; MW = 1'b1; BW = 1'b0; MAB = 16'h2002; MDBwrite = 16'hBEEF;
        #1 check("rst_mw_read_zero", MDBread, 16'h0000);
        @(negedge MCLK);
        MAB = 16'hC402; MDBwrite = 16'hDEAD;
        @(negedge MCLK);
        rst = 1'b0; MW = 1'b0;

        apply(mk("post_rst_2002",     16'h2002, 0, 0, 16'h0000, 16'h0000));
        apply(mk("post_rst_2000",     16'h2000, 0, 0, 16'h0000, 16'h0000));
        apply(mk("post_rst_23fe",     16'h23FE, 0, 0, 16'h0000, 16'h0000));
        apply(mk("post_rst_fram_c402",16'hC402, 0, 0, 16'h0000, 16'h1357));
        apply(mk("post_rst_fram_c400",16'hC400, 0, 0, 16'h0000, fram_c400_exp));
        apply(mk("post_rst_fram_fffe",16'hFFFE, 0, 0, 16'h0000, 16'hA5A5));

        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
